// File: rtl/mux4_rr_arbiter_if.sv
// Bus bundle for the 4-requester round-robin arbiter: requester side, shared
// payload datapath and downstream valid/ready handshake.
interface mux4_rr_arbiter_if;
  logic [3:0]  req_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [31:0] data3_i;
  logic [31:0] data4_i;
  logic [3:0]  last_i;
  logic [3:0]  ack_o;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic [1:0]  select_o;
  logic [3:0]  grant_o;

  modport master (
    output req_i, data1_i, data2_i, data3_i, data4_i, last_i, ready_i,
    input  ack_o, data_o, valid_o, select_o, grant_o
  );

  modport slave (
    input  req_i, data1_i, data2_i, data3_i, data4_i, last_i, ready_i,
    output ack_o, data_o, valid_o, select_o, grant_o
  );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin 4:1 arbiter with a one-entry registered output stage.
// Define RR_ARB_BURST_LOCK_EN to hold arbitration on a requester until last_i.
module mux4_rr_arbiter (
  input logic                    clk_i,
  input logic                    rst_i,
  mux4_rr_arbiter_if.slave       bus_io
);

  logic [31:0] r_data;
  logic        r_valid;
  logic [1:0]  r_select;
  logic [1:0]  r_ptr;

  logic [3:0]  w_elig;
  logic        w_cap_en;
  logic        w_win_found;
  logic [1:0]  w_win_idx;
  logic        w_capture;
  logic [31:0] w_win_data;

`ifdef RR_ARB_BURST_LOCK_EN
  logic        r_locked;
  logic [1:0]  r_lock_idx;

  assign w_elig = r_locked ? (bus_io.req_i & (4'b0001 << r_lock_idx)) : bus_io.req_i;
`else
  logic        w_unused_last;

  assign w_elig        = bus_io.req_i;
  assign w_unused_last = ^bus_io.last_i;
`endif

  // A same-cycle transfer frees the stage for a new capture.
  assign w_cap_en = ~r_valid | bus_io.ready_i;

  // Scan ptr+4 down to ptr+1 so the earliest position in the order wins.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = r_ptr;
    for (int i = 4; i >= 1; i--) begin
      if (w_elig[r_ptr + 2'(i)]) begin
        w_win_found = 1'b1;
        w_win_idx   = r_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    w_win_data = bus_io.data1_i;
    unique case (w_win_idx)
      2'd0: w_win_data = bus_io.data1_i;
      2'd1: w_win_data = bus_io.data2_i;
      2'd2: w_win_data = bus_io.data3_i;
      2'd3: w_win_data = bus_io.data4_i;
      default: w_win_data = bus_io.data1_i;
    endcase
  end

  assign w_capture = w_cap_en & w_win_found & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_data   <= 32'd0;
      r_valid  <= 1'b0;
      r_select <= 2'd0;
      r_ptr    <= 2'd3;
`ifdef RR_ARB_BURST_LOCK_EN
      r_locked   <= 1'b0;
      r_lock_idx <= 2'd0;
`endif
    end else if (w_capture) begin
      r_data   <= w_win_data;
      r_valid  <= 1'b1;
      r_select <= w_win_idx;
`ifdef RR_ARB_BURST_LOCK_EN
      if (bus_io.last_i[w_win_idx]) begin
        r_locked <= 1'b0;
        r_ptr    <= w_win_idx;
      end else begin
        r_locked   <= 1'b1;
        r_lock_idx <= w_win_idx;
      end
`else
      r_ptr    <= w_win_idx;
`endif
    end else if (r_valid && bus_io.ready_i) begin
      r_valid <= 1'b0;
    end
  end

  assign bus_io.ack_o    = w_capture ? (4'b0001 << w_win_idx) : 4'b0000;
  assign bus_io.data_o   = r_data;
  assign bus_io.valid_o  = r_valid;
  assign bus_io.select_o = r_select;
  assign bus_io.grant_o  = r_valid ? (4'b0001 << r_select) : 4'b0000;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed and randomized checks of mux4_rr_arbiter against a behavioural
// round-robin model; also builds with RR_ARB_BURST_LOCK_EN defined.
module tb_mux4_rr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] d [4];

  // Reference model state
  bit          m_valid;
  logic [31:0] m_data;
  int          m_sel;
  int          m_ptr;
  bit          m_locked;
  int          m_lock;

  // Values sampled from the DUT during the most recent step
  logic [3:0]  s_ack;
  logic [31:0] s_data;
  logic        s_valid;
  logic [1:0]  s_sel;

  logic [3:0]  exp_seq [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int find_win(input logic [3:0] elig, input int ptr);
    for (int i = 1; i <= 4; i++) begin
      if (elig[(ptr + i) % 4]) return (ptr + i) % 4;
    end
    return -1;
  endfunction

  // Called just after a falling edge: drive, check, cross the rising edge, update model.
  task automatic step(input logic [3:0] rq, input logic rdy, input logic rs,
                      input logic [3:0] lst, input bit do_chk);
    int         win;
    logic [3:0] elig;
    logic [3:0] exp_ack;
    bus.req_i   = rq;
    bus.ready_i = rdy;
    bus.last_i  = lst;
    rst         = rs;
    bus.data1_i = d[0];
    bus.data2_i = d[1];
    bus.data3_i = d[2];
    bus.data4_i = d[3];
    #1;
    elig = rq;
`ifdef RR_ARB_BURST_LOCK_EN
    if (m_locked) elig = rq & (4'b0001 << m_lock);
`endif
    win = -1;
    if (!rs && (!m_valid || rdy)) win = find_win(elig, m_ptr);
    exp_ack = (win >= 0) ? (4'b0001 << win) : 4'b0000;
    s_ack   = bus.ack_o;
    s_data  = bus.data_o;
    s_valid = bus.valid_o;
    s_sel   = bus.select_o;
    if (do_chk) begin
      check("ack", {28'd0, s_ack}, {28'd0, exp_ack});
      check("valid", {31'd0, s_valid}, {31'd0, m_valid});
      check("data", s_data, m_data);
      check("select", {30'd0, s_sel}, m_sel);
      check("grant", {28'd0, bus.grant_o}, m_valid ? (32'd1 << m_sel) : 32'd0);
    end
    @(posedge clk);
    if (rs) begin
      m_valid = 0; m_data = 32'd0; m_sel = 0; m_ptr = 3; m_locked = 0; m_lock = 0;
    end else if (win >= 0) begin
      m_valid = 1; m_data = d[win]; m_sel = win;
`ifdef RR_ARB_BURST_LOCK_EN
      if (lst[win]) begin
        m_locked = 0; m_ptr = win;
      end else begin
        m_locked = 1; m_lock = win;
      end
`else
      m_ptr = win;
`endif
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 4; k++) d[k] = $urandom;
    m_valid = 0; m_data = 32'd0; m_sel = 0; m_ptr = 3; m_locked = 0; m_lock = 0;

    step(4'b0000, 1'b0, 1'b1, 4'b0000, 0);
    step(4'b0000, 1'b0, 1'b1, 4'b0000, 1);
    check("reset_ack", {28'd0, s_ack}, 32'd0);
    check("reset_valid", {31'd0, s_valid}, 32'd0);

    // All requesting, downstream always ready: rotate starting at 0.
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1, 1'b0, 4'b1111, 1);
      check("rr_seq", {28'd0, s_ack}, {28'd0, exp_seq[i % 4]});
    end
    step(4'b0000, 1'b1, 1'b0, 4'b1111, 1);
    step(4'b0000, 1'b0, 1'b0, 4'b1111, 1);

    // Backpressure holds the beat stable.
    d[2] = 32'hDEADBEEF;
    step(4'b0100, 1'b0, 1'b0, 4'b1111, 1);
    check("bp_ack", {28'd0, s_ack}, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(4'b0100, 1'b0, 1'b0, 4'b1111, 1);
      check("bp_noack", {28'd0, s_ack}, 32'd0);
      check("bp_data", s_data, 32'hDEADBEEF);
      check("bp_sel", {30'd0, s_sel}, 32'd2);
      check("bp_valid", {31'd0, s_valid}, 32'd1);
    end
    step(4'b0000, 1'b1, 1'b0, 4'b1111, 1);
    step(4'b0000, 1'b0, 1'b0, 4'b1111, 1);
    check("drain_valid", {31'd0, s_valid}, 32'd0);
    check("drain_data", s_data, 32'hDEADBEEF);

    // Wrap-around between requesters 3 and 0.
    step(4'b1000, 1'b1, 1'b0, 4'b1111, 1);
    check("wrap_w3", {28'd0, s_ack}, 32'h8);
    step(4'b1001, 1'b1, 1'b0, 4'b1111, 1);
    check("wrap_w0", {28'd0, s_ack}, 32'h1);
    step(4'b1001, 1'b1, 1'b0, 4'b1111, 1);
    check("wrap_w3b", {28'd0, s_ack}, 32'h8);
    step(4'b0000, 1'b1, 1'b0, 4'b1111, 1);

    // Reset while full discards the beat.
    step(4'b0010, 1'b0, 1'b0, 4'b1111, 1);
    step(4'b0010, 1'b0, 1'b1, 4'b1111, 1);
    check("rst_ack", {28'd0, s_ack}, 32'd0);
    step(4'b0110, 1'b1, 1'b0, 4'b1111, 1);
    check("rst_valid", {31'd0, s_valid}, 32'd0);
    check("rst_data", s_data, 32'd0);
    check("rst_first", {28'd0, s_ack}, 32'h2);
    step(4'b0000, 1'b1, 1'b0, 4'b1111, 1);

    // Burst behaviour: requester 1 wins first, last_i[1] on the third beat.
    step(4'b0001, 1'b1, 1'b0, 4'b1111, 1);
`ifdef RR_ARB_BURST_LOCK_EN
    exp_seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0001};
`else
    exp_seq = '{4'b0010, 4'b0001, 4'b0010, 4'b0001};
`endif
    step(4'b0011, 1'b1, 1'b0, 4'b0000, 1);
    check("burst0", {28'd0, s_ack}, {28'd0, exp_seq[0]});
    step(4'b0011, 1'b1, 1'b0, 4'b0000, 1);
    check("burst1", {28'd0, s_ack}, {28'd0, exp_seq[1]});
    step(4'b0011, 1'b1, 1'b0, 4'b0010, 1);
    check("burst2", {28'd0, s_ack}, {28'd0, exp_seq[2]});
    step(4'b0011, 1'b1, 1'b0, 4'b0000, 1);
    check("burst3", {28'd0, s_ack}, {28'd0, exp_seq[3]});

    // Random traffic; payload changes only while its request is low.
    for (int n = 0; n < 600; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!bus.req_i[k]) d[k] = $urandom;
      end
      step(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
           4'($urandom), 1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Ports SHALL be one per line: name, direction, width, meaning; clock and reset are listed first.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_i  input  1  synchronous, active-high reset.
REQ-004 req_i  input  4  per-requester request; bit k corresponds to requester k (0..3).
REQ-005 data1_i..data4_i  input  32 each  requester 0..3 payload; held stable while that requester's req is high.
REQ-006 last_i  input  4  per-requester end-of-burst flag; used only when RR_ARB_BURST_LOCK_EN is defined.
REQ-007 ack_o  output  4  one-hot, one-cycle pulse; requester k's current beat is captured.
REQ-008 data_o  output  32  registered payload of the captured beat.
REQ-009 valid_o  output  1  data_o holds an untransferred beat.
REQ-010 ready_i  input  1  downstream accepts; transfer occurs when valid_o and ready_i are both 1.
REQ-011 select_o  output  2  index of the requester whose beat is in data_o; drives the shared 4:1 datapath select.
REQ-012 grant_o  output  4  one-hot decode of select_o while valid_o=1; 4'b0000 otherwise.

Function
REQ-013 Output stage SHALL have two states: EMPTY (valid_o=0) and FULL (valid_o=1).
REQ-014 Capture is enabled when state is EMPTY, or when state is FULL and ready_i=1 (the same-cycle transfer frees the stage).
REQ-015 On a capture-enabled cycle with at least one eligible req_i bit, the block SHALL select winner k, assert ack_o[k] in that cycle, and on the next edge load data_o with the data of requester k, select_o with k, and valid_o with 1.
REQ-016 Winner search order SHALL be ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr is the last winner; ptr updates to k at capture.
REQ-017 Latency SHALL be one cycle: req_i asserted in cycle N while EMPTY gives valid_o=1 in cycle N+1.
REQ-018 Throughput SHALL be one beat per cycle when ready_i is held at 1 and requests are pending.
REQ-019 On a transfer with no eligible request, the next state SHALL be EMPTY and data_o SHALL hold its last value.
REQ-020 While FULL with ready_i=0: data_o, select_o, and valid_o SHALL stay stable, and ack_o SHALL be 0.
REQ-021 ready_i while EMPTY SHALL be ignored.
REQ-022 A req_i bit dropped before its ack SHALL not be granted; no request is remembered.
REQ-023 ack_o SHALL never have more than one bit set, and SHALL be 0 when no capture occurs.

Reset
REQ-024 While rst_i=1 at a clock edge, the block SHALL clear valid_o, ack_o, and grant_o to 0; set data_o to 0 and select_o to 0; set ptr to 3 so requester 0 has first priority; and clear the burst lock.
REQ-025 A reset mid-operation SHALL discard any pending beat without asserting ack_o; arbitration resumes on the first cycle after rst_i falls.

Configuration
REQ-026 Macro RR_ARB_BURST_LOCK_EN SHALL compile burst locking in or out.
REQ-027 With RR_ARB_BURST_LOCK_EN defined:
- Capturing a beat from requester k with last_i[k]=0 SHALL lock arbitration to k.
- While locked, only req_i[k] is eligible.
- Capturing k's beat with last_i[k]=1 SHALL release the lock.
- ptr SHALL update only on lock release.
REQ-028 Without RR_ARB_BURST_LOCK_EN, last_i SHALL be ignored and every capture SHALL re-arbitrate per REQ-016.

Verification
REQ-029 After reset, req_i=4'b1111 and ready_i=1 held for 5 cycles -> ack_o sequence 0001, 0010, 0100, 1000, 0001; select_o lags ack by one cycle.
REQ-030 req_i=4'b0100 with data3_i=32'hDEADBEEF and ready_i=0 for 4 cycles -> exactly one ack_o=4'b0100; data_o=32'hDEADBEEF, select_o=2, and valid_o=1 stable for all 4 cycles; then ready_i=1 -> transfer, and valid_o=0 next cycle if req_i=0.
REQ-031 req_i=4'b1001 after winner 3 -> requester 0 wins next; after winner 0 -> requester 3 wins.
REQ-032 rst_i=1 while FULL with req_i=4'b0010 pending -> next cycle valid_o=0, ack_o=0, data_o=0; first grant after reset goes to lowest pending index.
REQ-033 With RR_ARB_BURST_LOCK_EN defined: req_i=4'b0011, requester 1 wins, last_i[1]=0 for 2 beats then 1 -> three consecutive ack_o=4'b0010, then ack_o=4'b0001; without the macro -> acks alternate 0010, 0001.
